// File: rtl/digit_pkg.sv
// Shared definitions for the 2-bit dual-rail digit datapath: digit encodings
// and the deserializer state type.
package digit_pkg;

  localparam logic [1:0] DIG_NULL    = 2'b00;
  localparam logic [1:0] DIG_ZERO    = 2'b01;
  localparam logic [1:0] DIG_ONE     = 2'b10;
  localparam logic [1:0] DIG_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    ERROR
  } deserStateT;

endpackage

// File: rtl/digit_deserializer_if.sv
// Serial-in / parallel-out handshake bundle of the digit deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface digit_deserializer_if #(
  parameter int WIDTH = 8
);

  logic [1:0]         serialDigit;
  logic               serialValid;
  logic               serialReady;
  logic [2*WIDTH-1:0] parallelData;
  logic               parallelValid;
  logic               parallelReady;
  logic               errorFlag;
  logic               clearError;

  modport slave (
    input  serialDigit, serialValid, parallelReady, clearError,
    output serialReady, parallelData, parallelValid, errorFlag
  );

  modport master (
    output serialDigit, serialValid, parallelReady, clearError,
    input  serialReady, parallelData, parallelValid, errorFlag
  );

endinterface

// File: rtl/digit_classify.sv
// Combinational classifier for one 2-bit encoded digit; shared with the
// reduction gates so both paths agree on what counts as data.
module digit_classify
  import digit_pkg::*;
(
  input  logic [1:0] digit,
  output logic       isNull,
  output logic       isData,
  output logic       isIllegal
);

  assign isNull    = (digit == DIG_NULL);
  assign isData    = (digit == DIG_ZERO) || (digit == DIG_ONE);
  assign isIllegal = (digit == DIG_ILLEGAL);

endmodule

// File: rtl/digit_deserializer.sv
// Assembles WIDTH serial digits into one dual-rail parallel word with
// valid/ready on both sides; an ILLEGAL digit aborts the word until cleared.
module digit_deserializer
  import digit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  digit_deserializer_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  deserStateT         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] word;
  logic               wordValid;
  logic               errorReg;

  logic               isNull;
  logic               isData;
  logic               isIllegal;
  logic               serialReadyInt;
  logic               accept;
  logic               takeData;
  logic               lastSlot;
  logic [WIDTH-1:0]   slotWe;

  digit_classify classify (
    .digit     (bus.serialDigit),
    .isNull    (isNull),
    .isData    (isData),
    .isIllegal (isIllegal)
  );

  // Input ready must follow parallelReady in the same cycle so HOLD can
  // emit a word and take the next digit without a bubble.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    serialReadyInt = 1'b0;
    case (state)
      COLLECT: serialReadyInt = 1'b1;
      HOLD:    serialReadyInt = bus.parallelReady;
      default: serialReadyInt = 1'b0;
    endcase
  end

  assign accept   = bus.serialValid && serialReadyInt;
  assign takeData = accept && isData;
  assign lastSlot = (count == CNT_W'(WIDTH - 1));

  // One-hot slot select; in HOLD count is 0, so a new digit lands in the first slot.
  always_comb begin
    slotWe = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) slotWe[i] = takeData && (i == WIDTH - 1 - int'(count));
      else           slotWe[i] = takeData && (i == int'(count));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the word register is
  // reset along with the control state so unused slots never hold anything but NULL.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state     <= COLLECT;
      count     <= '0;
      word      <= '0;
      wordValid <= 1'b0;
      errorReg  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept && !isNull) begin
            if (isIllegal) begin
              state    <= ERROR;
              count    <= '0;
              word     <= '0;
              errorReg <= 1'b1;
            end else begin
              for (int i = 0; i < WIDTH; i++)
                if (slotWe[i]) word[2*i +: 2] <= bus.serialDigit;
              if (lastSlot) begin
                state     <= HOLD;
                count     <= '0;
                wordValid <= 1'b1;
              end else begin
                count <= count + CNT_W'(1);
              end
            end
          end
        end

        HOLD: begin
          if (bus.parallelReady) begin
            if (accept && isIllegal) begin
              state     <= ERROR;
              word      <= '0;
              wordValid <= 1'b0;
              errorReg  <= 1'b1;
            end else begin
              // Emitted word is replaced by a cleared one holding at most the new digit.
              for (int i = 0; i < WIDTH; i++)
                word[2*i +: 2] <= slotWe[i] ? bus.serialDigit : DIG_NULL;
              if (takeData && lastSlot) begin
                state     <= HOLD;
                wordValid <= 1'b1;
              end else begin
                state     <= COLLECT;
                wordValid <= 1'b0;
                count     <= takeData ? CNT_W'(1) : '0;
              end
            end
          end
        end

        ERROR: begin
          if (bus.clearError) begin
            state    <= COLLECT;
            errorReg <= 1'b0;
          end
        end

        default: begin
          state     <= COLLECT;
          count     <= '0;
          word      <= '0;
          wordValid <= 1'b0;
          errorReg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.serialReady   = serialReadyInt;
  assign bus.parallelData  = word;
  assign bus.parallelValid = wordValid;
  assign bus.errorFlag     = errorReg;

endmodule

// File: tb/tb_digit_deserializer.sv
// Directed bench for digit_deserializer: LSB-first and MSB-first WIDTH=4
// instances plus a WIDTH=1 instance for the single-digit word boundary.
module tb_digit_deserializer;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  digit_deserializer_if #(.WIDTH(4)) ifA ();
  digit_deserializer_if #(.WIDTH(4)) ifB ();
  digit_deserializer_if #(.WIDTH(1)) ifC ();

  digit_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dutA (.Clock(Clock), .ResetN(ResetN), .bus(ifA.slave));
  digit_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dutB (.Clock(Clock), .ResetN(ResetN), .bus(ifB.slave));
  digit_deserializer #(.WIDTH(1), .MSB_FIRST(1'b0)) dutC (.Clock(Clock), .ResetN(ResetN), .bus(ifC.slave));

  task automatic sendA(input logic [1:0] d);
    ifA.serialDigit = d;
    ifA.serialValid = 1'b1;
    @(posedge Clock); #1;
    ifA.serialValid = 1'b0;
  endtask

  task automatic sendB(input logic [1:0] d);
    ifB.serialDigit = d;
    ifB.serialValid = 1'b1;
    @(posedge Clock); #1;
    ifB.serialValid = 1'b0;
  endtask

  task automatic drainA;
    ifA.parallelReady = 1'b1;
    @(posedge Clock); #1;
    ifA.parallelReady = 1'b0;
  endtask

  task automatic drainB;
    ifB.parallelReady = 1'b1;
    @(posedge Clock); #1;
    ifB.parallelReady = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (ifA.parallelData !== 8'h00) begin errors++; $display("FAIL reset_dataA got=%h exp=00", ifA.parallelData); end
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL reset_validA got=%b exp=0", ifA.parallelValid); end
    checks++; if (ifA.errorFlag !== 1'b0) begin errors++; $display("FAIL reset_errA got=%b exp=0", ifA.errorFlag); end
    checks++; if (ifA.serialReady !== 1'b1) begin errors++; $display("FAIL reset_readyA got=%b exp=1", ifA.serialReady); end
    checks++; if (ifB.parallelData !== 8'h00) begin errors++; $display("FAIL reset_dataB got=%h exp=00", ifB.parallelData); end
    checks++; if (ifC.serialReady !== 1'b1) begin errors++; $display("FAIL reset_readyC got=%b exp=1", ifC.serialReady); end
  endtask

  task automatic test_lsb_first;
    sendA(2'b01); sendA(2'b10); sendA(2'b10);
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL lsb_early_valid got=%b exp=0", ifA.parallelValid); end
    sendA(2'b01);
    checks++; if (ifA.parallelValid !== 1'b1) begin errors++; $display("FAIL lsb_valid got=%b exp=1", ifA.parallelValid); end
    checks++; if (ifA.parallelData !== 8'h69) begin errors++; $display("FAIL lsb_data got=%h exp=69", ifA.parallelData); end
    drainA;
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL lsb_drain_valid got=%b exp=0", ifA.parallelValid); end
    checks++; if (ifA.parallelData !== 8'h00) begin errors++; $display("FAIL lsb_drain_data got=%h exp=00", ifA.parallelData); end
    sendA(2'b01); sendA(2'b01); sendA(2'b10); sendA(2'b10);
    checks++; if (ifA.parallelData !== 8'hA5) begin errors++; $display("FAIL lsb_data2 got=%h exp=a5", ifA.parallelData); end
    drainA;
  endtask

  task automatic test_msb_first;
    sendB(2'b01); sendB(2'b10); sendB(2'b10); sendB(2'b01);
    checks++; if (ifB.parallelData[7:6] !== 2'b01) begin errors++; $display("FAIL msb_slot3 got=%b exp=01", ifB.parallelData[7:6]); end
    checks++; if (ifB.parallelData !== 8'h69) begin errors++; $display("FAIL msb_data got=%h exp=69", ifB.parallelData); end
    drainB;
    sendB(2'b01); sendB(2'b01); sendB(2'b10); sendB(2'b10);
    checks++; if (ifB.parallelValid !== 1'b1) begin errors++; $display("FAIL msb_valid2 got=%b exp=1", ifB.parallelValid); end
    checks++; if (ifB.parallelData !== 8'h5A) begin errors++; $display("FAIL msb_data2 got=%h exp=5a", ifB.parallelData); end
    drainB;
  endtask

  task automatic test_null_interleave;
    sendA(2'b01); sendA(2'b00); sendA(2'b10); sendA(2'b00); sendA(2'b00); sendA(2'b10);
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL null_early_valid got=%b exp=0", ifA.parallelValid); end
    sendA(2'b01);
    checks++; if (ifA.parallelValid !== 1'b1) begin errors++; $display("FAIL null_valid got=%b exp=1", ifA.parallelValid); end
    checks++; if (ifA.parallelData !== 8'h69) begin errors++; $display("FAIL null_data got=%h exp=69", ifA.parallelData); end
    drainA;
  endtask

  task automatic test_back_to_back;
    sendA(2'b01); sendA(2'b01); sendA(2'b10); sendA(2'b10);
    ifA.serialDigit   = 2'b01;
    ifA.serialValid   = 1'b1;
    ifA.parallelReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      checks++; if (ifA.serialReady !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, ifA.serialReady); end
      checks++; if (ifA.parallelData !== 8'hA5) begin errors++; $display("FAIL stall_data cyc=%0d got=%h exp=a5", i, ifA.parallelData); end
    end
    ifA.serialDigit   = 2'b10;
    ifA.parallelReady = 1'b1;
    @(posedge Clock); #1;
    ifA.serialValid   = 1'b0;
    ifA.parallelReady = 1'b0;
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", ifA.parallelValid); end
    checks++; if (ifA.parallelData !== 8'h02) begin errors++; $display("FAIL b2b_slot0 got=%h exp=02", ifA.parallelData); end
    sendA(2'b01); sendA(2'b01);
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL b2b_count got=%b exp=0", ifA.parallelValid); end
    sendA(2'b10);
    checks++; if (ifA.parallelData !== 8'h96) begin errors++; $display("FAIL b2b_word got=%h exp=96", ifA.parallelData); end
    drainA;
  endtask

  task automatic test_error;
    sendA(2'b10); sendA(2'b01); sendA(2'b11);
    checks++; if (ifA.errorFlag !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", ifA.errorFlag); end
    checks++; if (ifA.serialReady !== 1'b0) begin errors++; $display("FAIL err_ready got=%b exp=0", ifA.serialReady); end
    checks++; if (ifA.parallelData !== 8'h00) begin errors++; $display("FAIL err_data got=%h exp=00", ifA.parallelData); end
    ifA.serialDigit = 2'b10;
    ifA.serialValid = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    ifA.serialValid = 1'b0;
    checks++; if (ifA.errorFlag !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", ifA.errorFlag); end
    checks++; if (ifA.parallelData !== 8'h00) begin errors++; $display("FAIL err_ignored got=%h exp=00", ifA.parallelData); end
    ifA.clearError = 1'b1;
    @(posedge Clock); #1;
    ifA.clearError = 1'b0;
    checks++; if (ifA.errorFlag !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", ifA.errorFlag); end
    checks++; if (ifA.serialReady !== 1'b1) begin errors++; $display("FAIL err_clear_ready got=%b exp=1", ifA.serialReady); end
    sendA(2'b10); sendA(2'b10); sendA(2'b10); sendA(2'b10);
    checks++; if (ifA.parallelData !== 8'hAA) begin errors++; $display("FAIL err_next_word got=%h exp=aa", ifA.parallelData); end
    ifA.clearError = 1'b1;
    @(posedge Clock); #1;
    ifA.clearError = 1'b0;
    checks++; if (ifA.parallelValid !== 1'b1) begin errors++; $display("FAIL clear_ignored got=%b exp=1", ifA.parallelValid); end
    drainA;
  endtask

  task automatic test_reset_mid_word;
    sendA(2'b01); sendA(2'b10); sendA(2'b10);
    ResetN = 1'b0;
    @(posedge Clock); #1;
    ResetN = 1'b1;
    checks++; if (ifA.parallelData !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h exp=00", ifA.parallelData); end
    checks++; if (ifA.serialReady !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ifA.serialReady); end
    sendA(2'b01); sendA(2'b01); sendA(2'b01);
    checks++; if (ifA.parallelValid !== 1'b0) begin errors++; $display("FAIL rst_mid_count got=%b exp=0", ifA.parallelValid); end
    sendA(2'b10);
    checks++; if (ifA.parallelData !== 8'h95) begin errors++; $display("FAIL rst_mid_word got=%h exp=95", ifA.parallelData); end
    drainA;
  endtask

  task automatic test_width_one;
    ifC.serialDigit = 2'b10;
    ifC.serialValid = 1'b1;
    @(posedge Clock); #1;
    checks++; if (ifC.parallelValid !== 1'b1) begin errors++; $display("FAIL w1_valid got=%b exp=1", ifC.parallelValid); end
    checks++; if (ifC.parallelData !== 2'b10) begin errors++; $display("FAIL w1_data got=%b exp=10", ifC.parallelData); end
    ifC.serialDigit   = 2'b01;
    ifC.parallelReady = 1'b1;
    @(posedge Clock); #1;
    ifC.serialValid = 1'b0;
    checks++; if (ifC.parallelValid !== 1'b1) begin errors++; $display("FAIL w1_b2b_valid got=%b exp=1", ifC.parallelValid); end
    checks++; if (ifC.parallelData !== 2'b01) begin errors++; $display("FAIL w1_b2b_data got=%b exp=01", ifC.parallelData); end
    @(posedge Clock); #1;
    ifC.parallelReady = 1'b0;
    checks++; if (ifC.parallelValid !== 1'b0) begin errors++; $display("FAIL w1_drain_valid got=%b exp=0", ifC.parallelValid); end
    checks++; if (ifC.parallelData !== 2'b00) begin errors++; $display("FAIL w1_drain_data got=%b exp=00", ifC.parallelData); end
  endtask

  initial begin
    ifA.serialDigit = 2'b00; ifA.serialValid = 1'b0; ifA.parallelReady = 1'b0; ifA.clearError = 1'b0;
    ifB.serialDigit = 2'b00; ifB.serialValid = 1'b0; ifB.parallelReady = 1'b0; ifB.clearError = 1'b0;
    ifC.serialDigit = 2'b00; ifC.serialValid = 1'b0; ifC.parallelReady = 1'b0; ifC.clearError = 1'b0;
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    ResetN = 1'b1;

    test_reset();
    test_lsb_first();
    test_msb_first();
    test_null_interleave();
    test_back_to_back();
    test_error();
    test_reset_mid_word();
    test_width_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
